// File: rtl/bkm_csd_to_bin.sv
// Converts a pair of CSD words (X, Y) into two's-complement binary through a
// segmented borrow-chain pipeline: one WS-bit segment of P - N per stage.
module bkm_csd_to_bin #(
  parameter int WD = 72,
  parameter int WS = 24
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*WD-1:0] X_csd,
  input  logic [2*WD-1:0] Y_csd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WD:0]     X_bin,
  output logic [WD:0]     Y_bin,
  output logic            X_zero,
  output logic            Y_zero
);

  localparam int NS = (WD + WS) / WS;  // ceil((WD+1)/WS)
  localparam int DW = NS * WS;
  localparam int RW = WD + 1;

  // p/n carry the not-yet-subtracted upper segments, r the finished lower ones.
  typedef struct packed {
    logic [DW-1:0] p;
    logic [DW-1:0] n;
    logic [DW-1:0] r;
    logic          b;
  } lane_t;

  logic [NS-1:0] valid_q, valid_d;
  lane_t         x_q [NS];
  lane_t         x_d [NS];
  lane_t         y_q [NS];
  lane_t         y_d [NS];
  logic          x_zero_q, x_zero_d;
  logic          y_zero_q, y_zero_d;
  logic          advance;

  function automatic lane_t csd_lane(input logic [2*WD-1:0] csd);
    lane_t l;
    l = '0;
    for (int i = 0; i < WD; i++) begin
      l.p[i] = csd[2*i+1];
      l.n[i] = csd[2*i];
    end
    return l;
  endfunction

  // Subtract segment k; the WS+1-bit difference's top bit is the borrow out.
  function automatic lane_t seg_step(input lane_t cur, input int k);
    lane_t       nxt;
    logic [WS:0] diff;
    nxt  = cur;
    diff = {1'b0, cur.p[k*WS +: WS]} - {1'b0, cur.n[k*WS +: WS]}
         - {{WS{1'b0}}, cur.b};
    nxt.r[k*WS +: WS] = diff[WS-1:0];
    nxt.b             = diff[WS];
    return nxt;
  endfunction

  assign out_valid = valid_q[NS-1];
  assign advance   = srst & enable & (~out_valid | out_ready);
  assign in_ready  = advance;

  always_comb begin
    valid_d[0] = in_valid & advance;
    x_d[0]     = seg_step(csd_lane(X_csd), 0);
    y_d[0]     = seg_step(csd_lane(Y_csd), 0);
    for (int k = 1; k < NS; k++) begin
      valid_d[k] = valid_q[k-1];
      x_d[k]     = seg_step(x_q[k-1], k);
      y_d[k]     = seg_step(y_q[k-1], k);
    end
    // The last lane drives the outputs directly, so it must read 0 when empty.
    if (!valid_d[NS-1]) begin
      x_d[NS-1] = '0;
      y_d[NS-1] = '0;
    end
    x_zero_d = valid_d[NS-1] & (x_d[NS-1].r[RW-1:0] == '0);
    y_zero_d = valid_d[NS-1] & (y_d[NS-1].r[RW-1:0] == '0);
  end

  // NOTE: only valid bits, borrows and the output lane are reset; inner data
  // registers are don't-care while their valid bit is low.
  always_ff @(posedge clk) begin
    if (!srst) begin
      valid_q <= '0;
      for (int k = 0; k < NS; k++) begin
        x_q[k].b <= 1'b0;
        y_q[k].b <= 1'b0;
      end
      x_q[NS-1] <= '0;
      y_q[NS-1] <= '0;
      x_zero_q  <= 1'b0;
      y_zero_q  <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      x_zero_q <= x_zero_d;
      y_zero_q <= y_zero_d;
    end
  end

  assign X_bin  = x_q[NS-1].r[RW-1:0];
  assign Y_bin  = y_q[NS-1].r[RW-1:0];
  assign X_zero = x_zero_q;
  assign Y_zero = y_zero_q;

endmodule

// File: tb/tb_bkm_csd_to_bin.sv
// Directed bench for bkm_csd_to_bin at WD=8, WS=4 (three pipeline segments).
module tb_bkm_csd_to_bin;

  localparam int WD = 8;
  localparam int WS = 4;

  logic          clk = 1'b0;
  logic          srst, enable, in_valid, in_ready, out_valid, out_ready;
  logic [15:0]   X_csd, Y_csd;
  logic [8:0]    X_bin, Y_bin;
  logic          X_zero, Y_zero;

  int total = 0;
  int bad   = 0;

  logic [15:0] wx [5];
  logic [15:0] wy [5];
  logic [8:0]  ex [5];
  logic [8:0]  ey [5];

  always #5 clk = ~clk;

  bkm_csd_to_bin #(.WD(WD), .WS(WS)) dut (
    .clk(clk), .srst(srst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .X_csd(X_csd), .Y_csd(Y_csd),
    .out_valid(out_valid), .out_ready(out_ready),
    .X_bin(X_bin), .Y_bin(Y_bin), .X_zero(X_zero), .Y_zero(Y_zero)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X_csd = '0; Y_csd = '0;
    repeat (2) cyc();
    total++;
    if (out_valid !== 1'b0 || X_bin !== 9'h0 || Y_bin !== 9'h0 ||
        X_zero !== 1'b0 || Y_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b x=%h y=%h zx=%b zy=%b want all 0",
               out_valid, X_bin, Y_bin, X_zero, Y_zero);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    srst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] x, input logic [15:0] y,
                             input logic [8:0] exp_x, input logic [8:0] exp_y);
    X_csd = x; Y_csd = y; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready: got %b want 1", name, in_ready);
    end
    cyc();
    in_valid = 1'b0; X_csd = '0; Y_csd = '0;
    for (int i = 1; i <= 2; i++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL %s_early_valid: cycle %0d got %b want 0", name, i, out_valid);
      end
      cyc();
    end
    for (int h = 0; h < 2; h++) begin
      total++;
      if (out_valid !== 1'b1 || X_bin !== exp_x || Y_bin !== exp_y ||
          X_zero !== (exp_x == 9'h0) || Y_zero !== (exp_y == 9'h0)) begin
        bad++;
        $display("FAIL %s_result%0d: got v=%b x=%h y=%h zx=%b zy=%b want v=1 x=%h y=%h zx=%b zy=%b",
                 name, h, out_valid, X_bin, Y_bin, X_zero, Y_zero,
                 exp_x, exp_y, exp_x == 9'h0, exp_y == 9'h0);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    total++;
    if (out_valid !== 1'b0 || X_bin !== 9'h0 || Y_bin !== 9'h0 ||
        X_zero !== 1'b0 || Y_zero !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got v=%b x=%h y=%h want v=0 x=0 y=0", name, out_valid, X_bin, Y_bin);
    end
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         got  = 0;
    logic       hold_v = 1'b0;
    logic [8:0] hx = '0;
    logic [8:0] hy = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = !(c >= 4 && c < 8);
      if (sent < 5) begin
        in_valid = 1'b1; X_csd = wx[sent]; Y_csd = wy[sent];
      end else begin
        in_valid = 1'b0; X_csd = '0; Y_csd = '0;
      end
      #1;
      if (hold_v) begin
        total++;
        if (out_valid !== 1'b1 || X_bin !== hx || Y_bin !== hy) begin
          bad++;
          $display("FAIL b2b_hold: cycle %0d got v=%b x=%h y=%h want v=1 x=%h y=%h",
                   c, out_valid, X_bin, Y_bin, hx, hy);
        end
      end
      if (c >= 4 && c < 8) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_stall_ready: cycle %0d got %b want 0", c, in_ready);
        end
      end
      hold_v = out_valid & ~out_ready;
      hx = X_bin; hy = Y_bin;
      if (out_valid && out_ready) begin
        total++;
        if (X_bin !== ex[got] || Y_bin !== ey[got] ||
            X_zero !== (ex[got] == 9'h0) || Y_zero !== (ey[got] == 9'h0)) begin
          bad++;
          $display("FAIL b2b_word%0d: got x=%h y=%h zx=%b zy=%b want x=%h y=%h",
                   got, X_bin, Y_bin, X_zero, Y_zero, ex[got], ey[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid = 1'b0;
    total++;
    if (got != 5 || sent != 5) begin
      bad++; $display("FAIL b2b_count: got sent=%0d recv=%0d want 5/5", sent, got);
    end
    repeat (3) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_duplicate: got out_valid=%b want 0", out_valid);
      end
      cyc();
    end
  endtask

  task automatic test_enable_stall();
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      enable   = !(c >= 2 && c <= 4);
      in_valid = (c < 2);
      X_csd    = (c == 0) ? wx[2] : wx[3];
      Y_csd    = (c == 0) ? wy[2] : wy[3];
      #1;
      if (c >= 2 && c <= 4) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          bad++;
          $display("FAIL en_frozen: cycle %0d got rdy=%b v=%b want 0/0", c, in_ready, out_valid);
        end
      end
      if (out_valid && out_ready && enable) begin
        total++;
        if (c != 6 + got || X_bin !== ex[2+got] || Y_bin !== ey[2+got]) begin
          bad++;
          $display("FAIL en_word%0d: got cycle=%0d x=%h y=%h want cycle=%0d x=%h y=%h",
                   got, c, X_bin, Y_bin, 6 + got, ex[2+got], ey[2+got]);
        end
        got++;
      end
      cyc();
    end
    enable = 1'b1; in_valid = 1'b0;
    total++;
    if (got != 2) begin
      bad++; $display("FAIL en_count: got %0d want 2", got);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; X_csd = wx[c]; Y_csd = wy[c];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL flush_accept%0d: got %b want 1", c, in_ready);
      end
      cyc();
    end
    in_valid = 1'b0; srst = 1'b0;
    cyc();
    total++;
    if (out_valid !== 1'b0 || X_bin !== 9'h0 || Y_bin !== 9'h0 ||
        X_zero !== 1'b0 || Y_zero !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_cleared: got v=%b x=%h y=%h zx=%b zy=%b rdy=%b want all 0",
               out_valid, X_bin, Y_bin, X_zero, Y_zero, in_ready);
    end
    srst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_ghost: cycle %0d got out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    wx[0] = 16'hAAAA; wy[0] = 16'h5555; ex[0] = 9'h0FF; ey[0] = 9'h101;
    wx[1] = 16'h0006; wy[1] = 16'hFFFF; ex[1] = 9'h1FF; ey[1] = 9'h000;
    wx[2] = 16'h0002; wy[2] = 16'h0001; ex[2] = 9'h001; ey[2] = 9'h1FF;
    wx[3] = 16'h8000; wy[3] = 16'h4000; ex[3] = 9'h080; ey[3] = 9'h180;
    wx[4] = 16'h0009; wy[4] = 16'h6000; ex[4] = 9'h001; ey[4] = 9'h1C0;

    test_reset();
    test_single("all_pos", 16'hAAAA, 16'h0000, 9'h0FF, 9'h000);
    test_single("neg_and_zero", 16'h5555, 16'hFFFF, 9'h101, 9'h000);
    test_single("borrow_cross", 16'h0006, 16'h0024, 9'h1FF, 9'h002);
    test_back_to_back();
    test_enable_stall();
    test_reset_flush();
    test_single("resume", wx[4], wy[4], ex[4], ey[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bkm_csd_to_bin.md
BKM_CSD_TO_BIN -- requirements
Module: bkm_csd_to_bin

Interface
- REQ-001 The block SHALL have parameter WD, default 72: number of CSD digits per data word.
- REQ-002 The block SHALL have parameter WS, default 24: segment width, in bits, of the pipelined borrow chain.
- REQ-003 The block SHALL use derived constant NS = ceil((WD+1)/WS) as the pipeline depth in segments (default 4).
- REQ-004 clk  in  1  single clock; all state updates on rising edge.
- REQ-005 srst  in  1  reset, synchronous and active-low.
- REQ-006 enable  in  1  global advance qualifier; low freezes all state.
- REQ-007 in_valid  in  1  X_csd/Y_csd carry a word this cycle.
- REQ-008 in_ready  out  1  block accepts a word this cycle.
- REQ-009 X_csd  in  2*WD  CSD X word from bkm_steps; digit i = {X_csd[2i+1] (pos), X_csd[2i] (neg)}.
- REQ-010 Y_csd  in  2*WD  CSD Y word, same encoding as X_csd.
- REQ-011 out_valid  out  1  X_bin/Y_bin hold a result.
- REQ-012 out_ready  in  1  consumer takes the result this cycle.
- REQ-013 X_bin  out  WD+1  two's-complement value of X.
- REQ-014 Y_bin  out  WD+1  two's-complement value of Y.
- REQ-015 X_zero, Y_zero  out  1 each  the corresponding result equals 0; valid with out_valid.

Function
- REQ-016 Digit value SHALL be pos - neg: {0,0} = 0, {1,0} = +1, {0,1} = -1, {1,1} = 0.
- REQ-017 The result SHALL equal P - N exactly, with P = vector of pos bits and N = vector of neg bits, both zero-extended to NS*WS bits; the result is the low WD+1 bits and never overflows.
- REQ-018 Subtraction SHALL be split into NS segments of WS bits; stage k computes segment k using the registered borrow from stage k-1, with stage 0 borrow-in = 0.
- REQ-019 Not-yet-processed upper segments and already-computed lower segments SHALL travel through skew registers so each word stays aligned.
- REQ-020 X and Y SHALL share the same control pipeline and valid bits and complete in the same cycle.
- REQ-021 advance = enable & (~out_valid | out_ready); in_ready SHALL equal advance combinationally.
- REQ-022 A word SHALL be accepted when in_valid & in_ready.
- REQ-023 When advance is high, every stage and its valid bit SHALL shift by one; stage 0 valid SHALL load in_valid & in_ready.
- REQ-024 When advance is low, all stage registers, valid bits and outputs SHALL hold.
- REQ-025 Latency SHALL be NS cycles from the accepting edge to out_valid high with no stalls.
- REQ-026 Throughput SHALL be one word per cycle with no bubbles while out_ready = 1 and enable = 1.
- REQ-027 X_bin, Y_bin, X_zero and Y_zero SHALL be registered and stable while out_valid & ~out_ready.
- REQ-028 A result SHALL be consumed on out_valid & out_ready & enable; an accept and a consume in the same cycle SHALL both occur.
- REQ-029 No word SHALL ever be dropped or duplicated; at most NS words are in flight.
- REQ-030 Data registers MAY be don't-care while their valid bit is 0; outputs SHALL be 0 whenever out_valid = 0.

Reset
- REQ-031 On srst = 0 at a rising edge, all valid bits SHALL clear, X_bin = Y_bin = 0, X_zero = Y_zero = 0, and borrow registers = 0.
- REQ-032 Reset SHALL take priority over enable and the handshake; in-flight words are discarded.
- REQ-033 in_ready SHALL be 0 while srst = 0.
- REQ-034 Operation SHALL resume on the first edge with srst = 1.

Verification (WD=8, WS=4, NS=3, result width 9)
- REQ-035 All digits {1,0}, in_valid one cycle -> 3 cycles later out_valid = 1, X_bin = 9'h0FF, X_zero = 0.
- REQ-036 All digits {0,1} on X, all {1,1} on Y -> X_bin = 9'h101 (-255), Y_bin = 0, Y_zero = 1.
- REQ-037 Digit0 = +1, digit1 = -1, others 0 (X_csd = 16'h0006) -> X_bin = 9'h1FF (-1); the borrow crosses segments correctly.
- REQ-038 Stream 5 words back-to-back, out_ready = 0 for 4 cycles mid-stream -> in_ready drops, outputs hold, and all 5 results appear in order with correct values.
- REQ-039 enable = 0 for 3 cycles with 2 words in flight -> no state change; results appear 3 cycles late and are correct.
- REQ-040 srst = 0 for 1 cycle with 3 words in flight -> next cycle out_valid = 0, outputs 0, and none of the 3 words ever emerges.
